// File: rtl/spi_frame_rx_pkg.sv
// spi_frame_rx_pkg: shared frame geometry, sync pattern and receiver state type
package spi_frame_rx_pkg;
  localparam int          FRAME_W    = 480;
  localparam int          FRAME_H    = 360;
  localparam int          FRAME_BITS = FRAME_W * FRAME_H;
  localparam logic [15:0] SYNC_WORD  = 16'hBAD1;
  typedef enum logic [1:0] {HUNT, HEADER, PAYLOAD} rx_state_t;
endpackage

// File: rtl/spi_frame_rx.sv
// spi_frame_rx: SPI-slave frame deserializer driving the pixel FIFO write port
module spi_frame_rx
  import spi_frame_rx_pkg::*;
#(
  parameter int          FRAME_W   = spi_frame_rx_pkg::FRAME_W,
  parameter int          FRAME_H   = spi_frame_rx_pkg::FRAME_H,
  parameter int          DWIDTH    = 1,
  parameter logic [15:0] SYNC_WORD = spi_frame_rx_pkg::SYNC_WORD
) (
  input  logic              write_clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              mosi,
  input  logic              fifo_full,
  output logic              write_en,
  output logic [DWIDTH-1:0] din,
  output logic [15:0]       frame_num,
  output logic              frame_start,
  output logic              frame_done,
  output logic              overflow,
  output logic              busy
);
  localparam int NBITS = FRAME_W * FRAME_H;
  localparam int PW    = $clog2(NBITS);
  localparam int BW    = DWIDTH > 1 ? $clog2(DWIDTH) : 1;
  rx_state_t         r_state;
  logic [14:0]       r_sr;
  logic [14:0]       r_hdr_sr;
  logic [3:0]        r_hdr_cnt;
  logic [BW-1:0]     r_bit_cnt;
  logic [PW-1:0]     r_pix_cnt;
  logic [15:0]       w_sr16;
  logic [15:0]       w_hdr;
  logic [DWIDTH-1:0] w_word;
  logic              w_word_end;
  logic              w_frame_end;
  assign w_sr16      = {r_sr, mosi};
  assign w_hdr       = {r_hdr_sr, mosi};
  assign w_word_end  = r_bit_cnt == BW'(DWIDTH - 1);
  assign w_frame_end = r_pix_cnt == PW'(NBITS - 1);
  assign busy        = r_state != HUNT;
  if (NBITS % DWIDTH != 0) begin : g_bad_geometry
    $error("spi_frame_rx: FRAME_W*FRAME_H must be a multiple of DWIDTH");
  end
  if (DWIDTH == 1) begin : g_w1
    assign w_word = mosi;
  end else begin : g_wn
    logic [DWIDTH-2:0] r_word_sr;
    assign w_word = {r_word_sr, mosi};
    // Payload word shifter; the oldest bit lands in the word MSB
    always_ff @(posedge write_clk)
      r_word_sr <= (reset || cs_n) ? '0 : (r_state == PAYLOAD ? w_word[DWIDTH-2:0] : r_word_sr);
  end
  // Frame FSM: hunt for sync, capture header, pack payload words into the FIFO
  always_ff @(posedge write_clk) begin
    if (reset) begin
      r_state     <= HUNT;
      r_sr        <= '0;
      r_hdr_sr    <= '0;
      r_hdr_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_pix_cnt   <= '0;
      frame_num   <= '0;
      din         <= '0;
      write_en    <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      write_en    <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      if (cs_n) begin
        r_state <= HUNT;
        r_sr    <= '0;
      end else begin
        case (r_state)
          HUNT: begin
            r_sr <= w_sr16[14:0];
            if (w_sr16 == SYNC_WORD) begin
              r_state   <= HEADER;
              r_hdr_cnt <= '0;
            end
          end
          HEADER: begin
            r_hdr_sr  <= w_hdr[14:0];
            r_hdr_cnt <= r_hdr_cnt + 4'd1;
            if (r_hdr_cnt == 4'd15) begin
              frame_num   <= w_hdr;
              frame_start <= 1'b1;
              r_state     <= PAYLOAD;
              r_pix_cnt   <= '0;
              r_bit_cnt   <= '0;
            end
          end
          PAYLOAD: begin
            r_bit_cnt <= w_word_end ? '0 : r_bit_cnt + 1'b1;
            r_pix_cnt <= r_pix_cnt + 1'b1;
            if (w_word_end) begin
              write_en <= !fifo_full;
              if (fifo_full) overflow <= 1'b1;
              else           din      <= w_word;
            end
            if (w_frame_end) begin
              frame_done <= 1'b1;
              r_state    <= HUNT;
              r_sr       <= '0;
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end
endmodule
